boot_mem_sched: RTL and testbench

BOOT_MEM_SCHED -- requirements
Module: boot_mem_sched

---
 rtl/boot_mem_sched_if.sv | 35 +++
 rtl/boot_mem_sched.sv | 98 +++++++++
 tb/tb_boot_mem_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_mem_sched_if.sv
// Boot memory scheduler bus: loader pulses, core request path and shared memory port.
interface boot_mem_sched_if;
    logic        instr_valid;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        data_valid;
    logic [31:0] data_addr;
    logic [31:0] data_data;
    logic        load_done;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        mem_ready;
    logic        mem_en;
    logic        mem_we;
    logic        mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_grant;
    logic        init_end;
    logic        overflow_err;

    modport slave (
        input  instr_valid, instr_addr, instr_data, data_valid, data_addr, data_data,
               load_done, core_req, core_we, core_addr, core_wdata, mem_ready,
        output mem_en, mem_we, mem_sel, mem_addr, mem_wdata, core_grant, init_end, overflow_err
    );

    modport master (
        output instr_valid, instr_addr, instr_data, data_valid, data_addr, data_data,
               load_done, core_req, core_we, core_addr, core_wdata, mem_ready,
        input  mem_en, mem_we, mem_sel, mem_addr, mem_wdata, core_grant, init_end, overflow_err
    );
endinterface

// File: rtl/boot_mem_sched.sv
// Queues loader writes into a small FIFO, drains them to memory, then hands the
// memory port over to the core after a one-cycle init_end pulse.
module boot_mem_sched #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    boot_mem_sched_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {LOAD, DRAIN, HANDOFF, RUN} state_t;
    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    state_t        state;
    entry_t        fifo [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count, count_nxt, free, remain;
    logic          en_q, we_q, sel_q, grant_q, init_q, ovf_q;
    logic [31:0]   addr_q, wdata_q;
    logic          loading, pop, push_d, push_i, drop;
    entry_t        ent_d, ent_i, head_nxt;

    always_comb begin
        loading   = (state == LOAD) || (state == DRAIN);
        pop       = loading && en_q && bus.mem_ready;
        // Capacity is judged on occupancy before this cycle's pop: a full FIFO drops.
        free      = CW'(DEPTH) - count;
        push_d    = loading && bus.data_valid && (free != '0);
        push_i    = loading && bus.instr_valid && (free > CW'(push_d));
        drop      = (bus.data_valid && !push_d) || (bus.instr_valid && !push_i);
        ent_d     = {1'b1, bus.data_addr, bus.data_data};
        ent_i     = {1'b0, bus.instr_addr, bus.instr_data};
        count_nxt = count + CW'(push_d) + CW'(push_i) - CW'(pop);
        rd_nxt    = rd_ptr + PW'(pop);
        remain    = count - CW'(pop);
        // When the queue empties this cycle the new head is the first entry being pushed.
        head_nxt  = (remain == '0) ? (push_d ? ent_d : ent_i) : fifo[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push_d) fifo[wr_ptr] <= ent_d;
        if (push_i) fifo[wr_ptr + PW'(push_d)] <= ent_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            grant_q <= 1'b0;
            init_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_d) + PW'(push_i);
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            en_q   <= (count_nxt != '0);
            we_q   <= (count_nxt != '0);
            if (count_nxt != '0) {sel_q, addr_q, wdata_q} <= head_nxt;
            if (drop) ovf_q <= 1'b1;
            init_q <= 1'b0;
            case (state)
                LOAD:    if (bus.load_done) state <= DRAIN;
                DRAIN:   if (count == '0 && !bus.data_valid && !bus.instr_valid) begin
                             state  <= HANDOFF;
                             init_q <= 1'b1;
                         end
                HANDOFF: begin
                             state   <= RUN;
                             grant_q <= 1'b1;
                         end
                default: ;
            endcase
        end
    end

    // grant_q is set exactly when the FSM enters RUN, so it selects the core path.
    assign bus.mem_en       = grant_q ? bus.core_req   : en_q;
    assign bus.mem_we       = grant_q ? bus.core_we    : we_q;
    assign bus.mem_sel      = grant_q ? 1'b1           : sel_q;
    assign bus.mem_addr     = grant_q ? bus.core_addr  : addr_q;
    assign bus.mem_wdata    = grant_q ? bus.core_wdata : wdata_q;
    assign bus.core_grant   = grant_q;
    assign bus.init_end     = init_q;
    assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_boot_mem_sched.sv
// Scoreboard bench for boot_mem_sched: driver predicts accepted loader writes,
// monitor checks every issued memory write against the expected queue.
module tb_boot_mem_sched;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    boot_mem_sched_if bus ();

    boot_mem_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  occ = 0;
    bit  ovf_exp = 1'b0;
    bit  loader_open = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.instr_valid = 0; bus.instr_addr = 0; bus.instr_data = 0;
        bus.data_valid  = 0; bus.data_addr  = 0; bus.data_data  = 0;
        bus.load_done   = 0; bus.core_req   = 0; bus.core_we    = 0;
        bus.core_addr   = 0; bus.core_wdata = 0; bus.mem_ready  = 0;
    endtask

    // One clock of stimulus; the model decides which loader writes are kept.
    task automatic tick(input bit iv, input logic [31:0] ia, input logic [31:0] id,
                        input bit dv, input logic [31:0] da, input logic [31:0] dd,
                        input bit rdy, input bit ld);
        bit pop, dacc, iacc;
        bus.instr_valid = iv; bus.instr_addr = ia; bus.instr_data = id;
        bus.data_valid  = dv; bus.data_addr  = da; bus.data_data  = dd;
        bus.mem_ready   = rdy; bus.load_done = ld;
        if (loader_open) begin
            pop  = (occ > 0) && rdy;
            dacc = dv && (occ < DEPTH);
            iacc = iv && (occ + int'(dacc) < DEPTH);
            if ((dv && !dacc) || (iv && !iacc)) ovf_exp = 1'b1;
            occ = occ - int'(pop) + int'(dacc) + int'(iacc);
            if (dacc) exp_q.push_back('{1'b1, da, dd});
            if (iacc) exp_q.push_back('{1'b0, ia, id});
        end else if (iv || dv) begin
            ovf_exp = 1'b1;
        end
        @(posedge clk); #1;
        check("overflow_err", bus.overflow_err, ovf_exp);
        bus.instr_valid = 0;
        bus.data_valid  = 0;
    endtask

    task automatic idle(input bit rdy, input bit ld);
        tick(0, 0, 0, 0, 0, 0, rdy, ld);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        exp_q.delete();
        occ = 0; ovf_exp = 0; loader_open = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_sel", bus.mem_sel, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_core_grant", bus.core_grant, 0);
        check("rst_init_end", bus.init_end, 0);
        check("rst_overflow", bus.overflow_err, 0);
    endtask

    // Monitor: every accepted loader write must match the head of the expected queue.
    bit          prev_stall = 0;
    logic        prev_sel;
    logic [31:0] prev_addr, prev_data;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.mem_en && !bus.core_grant) begin
                if (prev_stall) begin
                    check("stall_hold_sel", bus.mem_sel, prev_sel);
                    check("stall_hold_addr", bus.mem_addr, prev_addr);
                    check("stall_hold_data", bus.mem_wdata, prev_data);
                end
                if (bus.mem_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL spurious_write: got addr %h with nothing expected", bus.mem_addr);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        check("wr_we", bus.mem_we, 1);
                        check("wr_sel", bus.mem_sel, e.sel);
                        check("wr_addr", bus.mem_addr, e.addr);
                        check("wr_data", bus.mem_wdata, e.data);
                    end
                end
            end
            prev_stall = !reset && bus.mem_en && !bus.mem_ready && !bus.core_grant;
            prev_sel   = bus.mem_sel;
            prev_addr  = bus.mem_addr;
            prev_data  = bus.mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        do_reset();

        // Core requests are ignored outside RUN.
        bus.core_req = 1; bus.core_addr = 32'h55;
        #1;
        check("load_core_ignored_en", bus.mem_en, 0);
        check("load_core_grant", bus.core_grant, 0);
        bus.core_req = 0;

        // Single instruction write issued one cycle after the pulse.
        tick(1, 32'h0, 32'h13, 0, 0, 0, 1, 0);
        check("single_en", bus.mem_en, 1);
        check("single_sel", bus.mem_sel, 0);
        check("single_addr", bus.mem_addr, 32'h0);
        check("single_data", bus.mem_wdata, 32'h13);
        idle(1, 0);
        check("single_popped", bus.mem_en, 0);

        // Simultaneous pulses: data entry goes first.
        tick(1, 32'h4, 32'h13, 1, 32'h100, 32'hDEADBEEF, 1, 0);
        check("both_first_sel", bus.mem_sel, 1);
        check("both_first_addr", bus.mem_addr, 32'h100);
        idle(1, 0);
        check("both_second_sel", bus.mem_sel, 0);
        check("both_second_addr", bus.mem_addr, 32'h4);
        idle(1, 0);
        check("both_done", bus.mem_en, 0);

        // Randomized loader traffic with backpressure.
        for (int i = 0; i < 250; i++)
            tick($urandom_range(0, 2) == 0, $urandom, $urandom,
                 $urandom_range(0, 2) == 0, $urandom, $urandom,
                 $urandom_range(0, 4) != 0, 0);
        for (int i = 0; i < 20 && occ > 0; i++) idle(1, 0);
        check("random_drained", exp_q.size(), 0);

        // Overflow: four queued under stall, fifth dropped.
        do_reset();
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 32'h1000 + 4 * i, 32'hA0 + i, 0, 0);
        tick(1, 32'h2000, 32'hBAD, 0, 0, 0, 0, 0);
        check("ovf_set", bus.overflow_err, 1);
        for (int i = 0; i < 10 && occ > 0; i++) idle(1, 0);
        check("ovf_four_committed", exp_q.size(), 0);
        idle(1, 0);
        check("ovf_fifth_not_issued", bus.mem_en, 0);

        // Handoff: two entries then init_end pulse then grant.
        do_reset();
        tick(1, 32'h8, 32'h11, 1, 32'h104, 32'h22, 1, 1);
        idle(1, 1);
        idle(1, 1);
        check("handoff_writes_done", exp_q.size(), 0);
        check("handoff_init_early", bus.init_end, 0);
        idle(1, 1);
        check("handoff_init_pulse", bus.init_end, 1);
        check("handoff_grant_early", bus.core_grant, 0);
        idle(1, 1);
        check("handoff_init_single", bus.init_end, 0);
        check("handoff_grant", bus.core_grant, 1);
        loader_open = 0;

        // RUN: core path is combinational.
        bus.core_req = 1; bus.core_we = 0; bus.core_addr = 32'h200;
        #1;
        check("run_en", bus.mem_en, 1);
        check("run_we", bus.mem_we, 0);
        check("run_addr", bus.mem_addr, 32'h200);
        check("run_sel", bus.mem_sel, 1);
        bus.core_we = 1; bus.core_wdata = 32'hCAFEF00D; bus.core_addr = 32'h204;
        #1;
        check("run_we1", bus.mem_we, 1);
        check("run_wdata", bus.mem_wdata, 32'hCAFEF00D);
        bus.core_req = 0;
        #1;
        check("run_idle_en", bus.mem_en, 0);
        idle(0, 0);
        check("run_load_done_low_grant", bus.core_grant, 1);
        check("run_ovf_before", bus.overflow_err, 0);
        tick(1, 32'h40, 32'h1, 0, 0, 0, 1, 0);
        check("run_pulse_ovf", bus.overflow_err, 1);

        // Reset during a stalled drain aborts the write.
        do_reset();
        tick(0, 0, 0, 1, 32'h300, 32'h55, 0, 1);
        idle(0, 1);
        idle(0, 1);
        check("stall_en", bus.mem_en, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1, 0);
            check("abort_no_en", bus.mem_en, 0);
        end
        tick(1, 32'h500, 32'h77, 0, 0, 0, 1, 0);
        check("reload_en", bus.mem_en, 1);
        idle(1, 0);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
